// File: rtl/softmax_argmax_ctrl.sv
// Read-side controller for the softmax FIFO: rewinds and streams NUM_CLASS signed
// scores, tracks the top-2 scores with their indices and reports them with a done pulse.
module softmax_argmax_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CLASS  = 10,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  fifo_rd_clr,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_inc,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_WIDTH-1:0]  top1_idx,
  output logic [DATA_WIDTH-1:0] top1_val,
  output logic [IDX_WIDTH-1:0]  top2_idx,
  output logic [DATA_WIDTH-1:0] top2_val,
  output logic [DATA_WIDTH:0]   margin
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

  state_t                        state;
  logic [IDX_WIDTH-1:0]          rd_cnt, smp_idx;
  logic [1:0]                    vld_pipe;
  logic signed [DATA_WIDTH-1:0]  best1, best2, nb1, nb2, smp;
  logic [IDX_WIDTH-1:0]          idx1, idx2, nidx1, nidx2;
  logic [DATA_WIDTH:0]           mg;

  // vld_pipe[0] is the read strobe, vld_pipe[1] marks fifo_data as valid.
  assign vld_pipe[0] = fifo_rd_en;
  assign smp         = $signed(fifo_data);

  // Next-state of the top-2 tracker; also feeds the result load in DRAIN so the
  // last sample is included without an extra cycle.
  always_comb begin
    nb1   = best1;
    nb2   = best2;
    nidx1 = idx1;
    nidx2 = idx2;
    if (vld_pipe[1]) begin
      if (smp > best1) begin
        nb2   = best1;
        nidx2 = idx1;
        nb1   = smp;
        nidx1 = smp_idx;
      end else if (smp > best2) begin
        nb2   = smp;
        nidx2 = smp_idx;
      end
    end
  end

  assign mg = {nb1[DATA_WIDTH-1], nb1} - {nb2[DATA_WIDTH-1], nb2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd_cnt      <= '0;
      smp_idx     <= '0;
      vld_pipe[1] <= 1'b0;
      best1       <= '0;
      best2       <= '0;
      idx1        <= '0;
      idx2        <= '0;
      fifo_rd_clr <= 1'b0;
      fifo_rd_en  <= 1'b0;
      fifo_rd_inc <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      top1_idx    <= '0;
      top1_val    <= '0;
      top2_idx    <= '0;
      top2_val    <= '0;
      margin      <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      smp_idx     <= rd_cnt;
      best1       <= nb1;
      best2       <= nb2;
      idx1        <= nidx1;
      idx2        <= nidx2;
      fifo_rd_clr <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state       <= S_CLR;
          fifo_rd_clr <= 1'b1;
          busy        <= 1'b1;
        end
        S_CLR: begin
          state       <= S_READ;
          fifo_rd_en  <= 1'b1;
          fifo_rd_inc <= 1'b1;
          rd_cnt      <= '0;
          best1       <= MOST_NEG;
          best2       <= MOST_NEG;
          idx1        <= '0;
          idx2        <= '0;
        end
        S_READ: begin
          if (rd_cnt == LAST_IDX) begin
            state       <= S_DRAIN;
            fifo_rd_en  <= 1'b0;
            fifo_rd_inc <= 1'b0;
          end else begin
            rd_cnt <= rd_cnt + IDX_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          state    <= S_DONE;
          done     <= 1'b1;
          top1_idx <= nidx1;
          top1_val <= nb1;
          top2_idx <= nidx2;
          top2_val <= nb2;
          margin   <= mg;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
